svga_timing_gen: RTL
====================

# svga_timing_gen

Generates 800x600 SVGA raster timing at a 36 MHz pixel clock. It drives the pixel coordinates consumed by the game renderer, then registers the renderer's colour back onto the VGA pins with matching sync and blanking. It is the source end of the `h_coord`/`v_coord` → `red`/`green`/`blue` interface. It also supplies line/frame strobes and a frame counter for frame-paced logic.

## Interface
Parameters:
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 72, horizontal sync width (pixels)
- `H_BP`, 128, horizontal back porch (pixels); H_TOTAL = 1024
- `V_ACTIVE`, 600, visible lines
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 22, vertical back porch (lines); V_TOTAL = 625
- `H_POL`, 1, active level of `vga_hs`
- `V_POL`, 1, active level of `vga_vs`
- `RGB_LATENCY`, 0, pipeline depth (0..3) of the colour source relative to the coordinates

Ports:
- `pixel_clk` in 1: pixel clock, 36 MHz
- `rst_n` in 1: asynchronous, active-low reset
- `red_in`, `green_in`, `blue_in` in 4 each: colour from the renderer
- `h_coord` out 11: horizontal counter, 0..H_TOTAL-1
- `v_coord` out 10: vertical counter, 0..V_TOTAL-1
- `display_on` out 1: current coordinates are in the visible area
- `end_of_line` out 1: one-cycle strobe, last pixel of each line
- `end_of_frame` out 1: one-cycle strobe, last pixel of the frame
- `frame_count` out 16: completed-frame counter
- `vga_hs`, `vga_vs` out 1 each: sync outputs to the pins
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour outputs to the pins

## Operation
- **Horizontal counter `h_cnt`.** Increments every cycle. At H_TOTAL-1 it wraps to 0 and advances `v_cnt`.
- **Vertical counter `v_cnt`.** Wraps from V_TOTAL-1 to 0 on the same cycle `h_cnt` wraps.
- **Coordinate outputs.** `h_coord` = `h_cnt` and `v_coord` = `v_cnt`, driven directly from registers. They count through the blanking intervals as well.
- **`display_on`.** Combinational: (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- **Raw horizontal sync.** Active for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 824..895.
- **Raw vertical sync.** Active for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. lines 601..602, for the whole line.
- **`end_of_line`.** Equals (`h_cnt` == H_TOTAL-1). Combinational, aligned with the coordinates.
- **`end_of_frame`.** Equals `end_of_line` && (`v_cnt` == V_TOTAL-1).
- **`frame_count`.** Increments by 1 on every `end_of_frame` cycle and wraps 65535 → 0.
- **Delay line.** Raw hs, raw vs and `display_on` pass through a shift register RGB_LATENCY stages deep. With RGB_LATENCY = 0 there is no delay.
- **Output register (one stage, every cycle):**
  - `vga_hs` = delayed raw hs ? H_POL : !H_POL
  - `vga_vs` = delayed raw vs ? V_POL : !V_POL
  - `vga_r`/`vga_g`/`vga_b` = delayed `display_on` ? `*_in` : 0
- **Blanking.** Colour is forced to 0 outside the visible area. This happens regardless of `*_in`.

## Timing
- **Reset (asynchronous, immediate, no clock required):**
  - `h_cnt` = 0, `v_cnt` = 0, `frame_count` = 0
  - all delay-line stages cleared: sync inactive, `display_on` = 0
  - `vga_hs` = !H_POL, `vga_vs` = !V_POL
  - `vga_r`/`vga_g`/`vga_b` = 0
- **Release.** First clock after `rst_n` rises: `h_coord` = 1. The coordinate sequence restarts at (0,0); partial lines are not resumed.
- **Strobes while in reset.** With counters at (0,0), `display_on` = 1 and `end_of_line` = `end_of_frame` = 0.
- **Colour source.** `*_in` must be a function of the coordinates presented RGB_LATENCY cycles earlier.
- **Pin latency.** `vga_*` reflect coordinates from RGB_LATENCY+1 cycles earlier.
- **Sync/colour alignment.** Sync and colour are always mutually aligned at the pins.
- **Line and frame lengths.** Line = 1024 cycles; frame = 640000 cycles (56.25 Hz).
- **Sync widths.** `vga_hs` active for exactly 72 consecutive cycles per line. `vga_vs` active for exactly 2048 consecutive cycles per frame.
- **`vga_vs` edges.** Both edges coincide with the cycle where the delayed horizontal position is 0.

## Test plan
- **Reset values.** Assert `rst_n` = 0 with no clock running → immediately `vga_hs` = 0, `vga_vs` = 0, `vga_r/g/b` = 0, `h_coord` = 0, `v_coord` = 0, `frame_count` = 0. After release, `h_coord` counts 1, 2, 3…
- **Horizontal sync.** RGB_LATENCY = 0 → `vga_hs` rises the cycle after `h_coord` = 824, stays high 72 cycles, falls the cycle after `h_coord` = 896. Period 1024 cycles.
- **Vertical sync and strobes.** `vga_vs` high for 2048 cycles, starting the cycle after (`h_coord`=0, `v_coord`=601). `end_of_frame` pulses every 640000 cycles; `frame_count` 0→1→2 on successive pulses.
- **Blanking.** `red_in` held at 4'hF → `vga_r` = F for positions h 0..799 on lines 0..599. `vga_r` = 0 at h 800..1023 and on lines 600..624.
- **Pipeline alignment.** RGB_LATENCY = 2, `red_in` = F only when the coordinate seen 2 cycles earlier was h 10..19 → `vga_r` = F for exactly the ten cycles where the delayed `display_on` position is 10..19. `vga_hs` rises 3 cycles after `h_coord` = 824.
- **Reset mid-frame.** Drop `rst_n` at (h=500, v=300) → all outputs return to reset values asynchronously. After release the next `end_of_frame` occurs 640000 cycles later, and `frame_count` wraps 65535 → 0 when preloaded via a long run.

Source files
------------

// File: rtl/svga_timing_gen.sv
// SVGA raster timing source: pixel coordinates out to the renderer, colour
// registered back onto the VGA pins with matching sync and blanking.
module svga_timing_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 24,
    parameter int H_SYNC      = 72,
    parameter int H_BP        = 128,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 22,
    parameter int H_POL       = 1,
    parameter int V_POL       = 1,
    parameter int RGB_LATENCY = 0
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [10:0] h_coord,
    output logic [9:0]  v_coord,
    output logic        display_on,
    output logic        end_of_line,
    output logic        end_of_frame,
    output logic [15:0] frame_count,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ON    = 1'(H_POL);
    localparam logic        VS_ON    = 1'(V_POL);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        hs_raw;
    logic        vs_raw;
    logic [2:0]  raw_bus;
    logic [2:0]  dly_bus;

    assign h_coord      = h_cnt;
    assign v_coord      = v_cnt;
    assign display_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign end_of_line  = (h_cnt == H_LAST);
    assign end_of_frame = end_of_line && (v_cnt == V_LAST);
    assign hs_raw       = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_raw       = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign raw_bus      = {hs_raw, vs_raw, display_on};

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_count <= '0;
        end else begin
            if (end_of_line) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST)
                    v_cnt <= '0;
                else
                    v_cnt <= v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
            if (end_of_frame)
                frame_count <= frame_count + 16'd1;
        end
    end

    // Sync and display-enable follow the renderer's colour pipeline so that
    // sync, blanking and colour stay mutually aligned at the pins.
    generate
        if (RGB_LATENCY == 0) begin : g_no_dly
            assign dly_bus = raw_bus;
        end else begin : g_dly
            logic [2:0] stage_q [RGB_LATENCY];

            always_ff @(posedge pixel_clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RGB_LATENCY; i++)
                        stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= raw_bus;
                    for (int i = 1; i < RGB_LATENCY; i++)
                        stage_q[i] <= stage_q[i-1];
                end
            end

            assign dly_bus = stage_q[RGB_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs <= !HS_ON;
            vga_vs <= !VS_ON;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_hs <= dly_bus[2] ? HS_ON : !HS_ON;
            vga_vs <= dly_bus[1] ? VS_ON : !VS_ON;
            vga_r  <= dly_bus[0] ? red_in   : 4'h0;
            vga_g  <= dly_bus[0] ? green_in : 4'h0;
            vga_b  <= dly_bus[0] ? blue_in  : 4'h0;
        end
    end

endmodule
